mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_rr_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the scratch-memory arbiter.
// Holds the FSM state encoding, the default bus widths and the index-width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Bits needed to hold a requester index (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotate-priority picker: returns the first set request at or above the
// pointer, wrapping modulo NREQ. Purely combinational so other arbiters
// (e.g. the framebuffer bus arbiter) can reuse it.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scan from farthest to nearest so the nearest set bit to the pointer wins.
    always_comb begin
        o_grant = '0;
        o_valid = |i_req;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NREQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NREQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (i_req[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port scratch memory
// between NREQ requesters. One transaction in flight: IDLE picks a winner,
// BUSY drives the memory until done, RESP pulses ack for one cycle.
// Optional abort-on-timeout is enabled with the macro MEM_ARBITER_TIMEOUT_EN;
// without it BUSY waits for mem_done indefinitely and err stays 0.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        rdata,
    output logic [NREQ-1:0]          err,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data_in,
    output logic                     mem_w_enable,
    output logic                     mem_r_enable,
    input  logic                     mem_done,
    input  logic [DATA_W-1:0]        mem_data_out
);

    localparam int IDX_W = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mem_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_valid;
    logic             w_timeout;
    logic [NREQ-1:0]  w_grant_oh;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_valid (w_valid)
    );

    assign w_grant_oh = NREQ'(1) << r_grant;
    assign w_ptr_next = (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_timer;

    // Count cycles spent in BUSY; held at zero elsewhere so entry starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state != BUSY) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_state == BUSY) && (r_timer == CNT_W'(TIMEOUT - 1));

    // Flag an abort alongside ack; a done arriving on the timeout cycle wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= '0;
        end else if (w_timeout && !mem_done) begin
            err <= w_grant_oh;
        end else begin
            err <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: grant from IDLE, leave BUSY on done/timeout, RESP lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = BUSY;
            BUSY:    if (mem_done || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered datapath: latch the winner, drive memory, return data and ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_grant      <= '0;
            ack          <= '0;
            rdata        <= '0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_w_enable <= 1'b0;
            mem_r_enable <= 1'b0;
        end else begin
            ack   <= '0;
            rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant      <= w_pick;
                        mem_addr     <= req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                        mem_data_in  <= req_wdata[int'(w_pick)*DATA_W +: DATA_W];
                        mem_w_enable <= req_we[w_pick];
                        mem_r_enable <= !req_we[w_pick];
                    end
                end
                BUSY: begin
                    if (mem_done || w_timeout) begin
                        mem_w_enable <= 1'b0;
                        mem_r_enable <= 1'b0;
                        ack          <= w_grant_oh;
                        if (mem_done && mem_r_enable) begin
                            rdata <= mem_data_out;
                        end
                    end
                end
                RESP: begin
                    r_ptr <= w_ptr_next;
                end
                default: begin
                end
            endcase
        end
    end

    // A requester must keep req high until its ack; the transaction still completes if not.
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == BUSY) |-> req[r_grant]);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a small memory responder answers the enables
// after a programmable number of cycles; expected acks are queued when a
// request is driven and popped when the DUT acknowledges.
module tb_mem_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TOUT = 8;

   logic               clk;
   logic               rst_n;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    ack;
   logic [DW-1:0]      rdata;
   logic [NREQ-1:0]    err;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_data_in;
   logic               mem_w_enable;
   logic               mem_r_enable;
   logic               mem_done;
   logic [DW-1:0]      mem_data_out;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      logic          isErr;
   } exp_t;

   exp_t expQ[$];
   int total = 0;
   int bad = 0;

   int            memLat = 1;
   logic [DW-1:0] memRdData = '0;
   bit            memEcho = 1'b0;
   bit            memAuto = 1'b1;
   int            enCnt = 0;

   mem_arbiter #(
      .NREQ    (NREQ),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .ack          (ack),
      .rdata        (rdata),
      .err          (err),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_w_enable (mem_w_enable),
      .mem_r_enable (mem_r_enable),
      .mem_done     (mem_done),
      .mem_data_out (mem_data_out)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: raises done in the memLat-th enabled cycle (memLat=0 never answers).
   initial begin
      mem_done = 1'b0;
      mem_data_out = '0;
      forever begin
         @(negedge clk);
         if (memAuto) begin
            if (mem_r_enable || mem_w_enable) enCnt++;
            else enCnt = 0;
            mem_done = (memLat > 0) && (enCnt == memLat);
            mem_data_out = memEcho ? ~mem_addr : memRdData;
         end
      end
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task test_reset;
      rst_n = 1'b0;
      req = '0;
      req_we = '0;
      req_addr = '0;
      req_wdata = '0;
      memLat = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (ack !== '0) begin bad++; $display("[TB] FAIL reset_ack got %b required 0", ack); end
      total++; if (err !== '0) begin bad++; $display("[TB] FAIL reset_err got %b required 0", err); end
      total++; if (rdata !== '0) begin bad++; $display("[TB] FAIL reset_rdata got %h required 0", rdata); end
      total++; if (mem_addr !== '0) begin bad++; $display("[TB] FAIL reset_addr got %h required 0", mem_addr); end
      total++; if (mem_data_in !== '0) begin bad++; $display("[TB] FAIL reset_data_in got %h required 0", mem_data_in); end
      total++;
      if ({mem_w_enable, mem_r_enable} !== 2'b00) begin
         bad++; $display("[TB] FAIL reset_enables got %b required 00", {mem_w_enable, mem_r_enable});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task test_contention;
      exp_t            e;
      int              got;
      int              lastCyc;
      logic [NREQ-1:0] expAck;
      memLat = 1;
      memEcho = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW] = 32'h100 + 32'(i * 4);
         req_wdata[i*DW +: DW] = 32'h7700 + 32'(i);
      end
      req_we = 4'b0010;
      for (int n = 0; n < 5; n++) begin
         e.idx = n % NREQ;
         e.data = (e.idx == 1) ? '0 : ~(32'h100 + 32'(e.idx * 4));
         e.isErr = 1'b0;
         expQ.push_back(e);
      end
      req = 4'hF;
      got = 0;
      lastCyc = 0;
      for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
         @(negedge clk);
         if (ack !== '0) begin
            e = expQ.pop_front();
            expAck = NREQ'(1) << e.idx;
            total++; if (ack !== expAck) begin bad++; $display("[TB] FAIL contention_ack got %b required %b", ack, expAck); end
            total++; if (rdata !== e.data) begin bad++; $display("[TB] FAIL contention_rdata got %h required %h", rdata, e.data); end
            total++; if (err !== '0) begin bad++; $display("[TB] FAIL contention_err got %b required 0", err); end
            total++;
            if (got == 0) begin
               if (cyc != 2) begin bad++; $display("[TB] FAIL contention_min_latency got %0d required 2", cyc); end
            end else if (cyc - lastCyc != 3) begin
               bad++; $display("[TB] FAIL contention_spacing got %0d required 3", cyc - lastCyc);
            end
            lastCyc = cyc;
            got++;
            if (got == 5) req = '0;
         end
      end
      total++;
      if (got != 5) begin
         bad++; $display("[TB] FAIL contention_count got %0d required 5", got);
         req = '0;
         expQ.delete();
      end
   endtask

   task test_single_read;
      exp_t e;
      int   enCycles;
      int   ackCyc;
      bit   pathBad;
      memLat = 3;
      memEcho = 1'b0;
      memRdData = 32'hA5;
      @(posedge clk); #1;
      req_we[2] = 1'b0;
      req_addr[2*AW +: AW] = 32'h10;
      req[2] = 1'b1;
      e.idx = 2; e.data = 32'hA5; e.isErr = 1'b0;
      expQ.push_back(e);
      enCycles = 0; ackCyc = -1; pathBad = 1'b0;
      for (int cyc = 0; cyc < 40 && ackCyc < 0; cyc++) begin
         @(negedge clk);
         if (mem_r_enable === 1'b1) begin
            enCycles++;
            if (mem_addr !== 32'h10 || mem_w_enable !== 1'b0) pathBad = 1'b1;
         end
         if (ack !== '0) begin
            ackCyc = cyc;
            req[2] = 1'b0;
            total++;
            if (expQ.size() == 0) begin
               bad++; $display("[TB] FAIL read_unexpected_ack got %b required none", ack);
            end else begin
               e = expQ.pop_front();
               if (ack !== 4'b0100 || rdata !== e.data || err !== '0) begin
                  bad++; $display("[TB] FAIL read_ack got ack=%b rdata=%h err=%b required ack=0100 rdata=%h err=0000", ack, rdata, err, e.data);
               end
            end
         end
      end
      total++; if (ackCyc != 4) begin bad++; $display("[TB] FAIL read_latency got %0d required 4", ackCyc); end
      total++; if (enCycles != 3) begin bad++; $display("[TB] FAIL read_enable_cycles got %0d required 3", enCycles); end
      total++; if (pathBad) begin bad++; $display("[TB] FAIL read_mem_path got wrong addr/enable required addr=10 w_enable=0"); end
      if (ackCyc < 0) begin req[2] = 1'b0; expQ.delete(); end
      @(negedge clk);
      total++;
      if (ack !== '0 || rdata !== '0) begin
         bad++; $display("[TB] FAIL read_pulse_width got ack=%b rdata=%h required ack=0000 rdata=0", ack, rdata);
      end
   endtask

   task test_single_write;
      exp_t e;
      int   enCycles;
      int   ackCyc;
      bit   pathBad;
      memLat = 2;
      memEcho = 1'b1;
      @(posedge clk); #1;
      req_we[0] = 1'b1;
      req_addr[0*AW +: AW] = 32'h4;
      req_wdata[0*DW +: DW] = 32'h3C;
      req[0] = 1'b1;
      e.idx = 0; e.data = '0; e.isErr = 1'b0;
      expQ.push_back(e);
      enCycles = 0; ackCyc = -1; pathBad = 1'b0;
      for (int cyc = 0; cyc < 40 && ackCyc < 0; cyc++) begin
         @(negedge clk);
         if (mem_w_enable === 1'b1) begin
            enCycles++;
            if (mem_data_in !== 32'h3C || mem_addr !== 32'h4 || mem_r_enable !== 1'b0) pathBad = 1'b1;
         end
         if (ack !== '0) begin
            ackCyc = cyc;
            req[0] = 1'b0;
            total++;
            if (expQ.size() == 0) begin
               bad++; $display("[TB] FAIL write_unexpected_ack got %b required none", ack);
            end else begin
               e = expQ.pop_front();
               if (ack !== 4'b0001 || rdata !== e.data || err !== '0) begin
                  bad++; $display("[TB] FAIL write_ack got ack=%b rdata=%h err=%b required ack=0001 rdata=0 err=0000", ack, rdata, err);
               end
            end
         end
      end
      total++; if (ackCyc != 3) begin bad++; $display("[TB] FAIL write_latency got %0d required 3", ackCyc); end
      total++; if (enCycles != 2) begin bad++; $display("[TB] FAIL write_enable_cycles got %0d required 2", enCycles); end
      total++; if (pathBad) begin bad++; $display("[TB] FAIL write_mem_path got wrong data/addr/enable required data_in=3c addr=4"); end
      if (ackCyc < 0) begin req[0] = 1'b0; expQ.delete(); end
   endtask

   task test_stray_done;
      @(posedge clk); #1;
      memAuto = 1'b0;
      req = '0;
      mem_done = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         total++;
         if (ack !== '0 || mem_r_enable !== 1'b0 || mem_w_enable !== 1'b0 || rdata !== '0) begin
            bad++; $display("[TB] FAIL stray_done got ack=%b r_en=%b w_en=%b rdata=%h required all 0", ack, mem_r_enable, mem_w_enable, rdata);
         end
      end
      mem_done = 1'b0;
      enCnt = 0;
      memAuto = 1'b1;
   endtask

   task test_reset_mid_busy;
      exp_t            e;
      int              got;
      logic [NREQ-1:0] expAck;
      memLat = 0;
      memEcho = 1'b1;
      @(posedge clk); #1;
      req_we = '0;
      req_addr[2*AW +: AW] = 32'h20;
      req[2] = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (mem_r_enable !== 1'b1) begin bad++; $display("[TB] FAIL midbusy_waiting got r_en=%b required 1", mem_r_enable); end
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (ack !== '0 || mem_r_enable !== 1'b0 || mem_w_enable !== 1'b0 || mem_addr !== '0) begin
         bad++; $display("[TB] FAIL midbusy_reset got ack=%b r_en=%b w_en=%b addr=%h required all 0", ack, mem_r_enable, mem_w_enable, mem_addr);
      end
      req[2] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      memLat = 1;
      req_addr[0*AW +: AW] = 32'h30;
      req_addr[3*AW +: AW] = 32'h3C;
      e.idx = 0; e.data = ~32'h30; e.isErr = 1'b0; expQ.push_back(e);
      e.idx = 3; e.data = ~32'h3C; e.isErr = 1'b0; expQ.push_back(e);
      req = 4'b1001;
      got = 0;
      for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
         @(negedge clk);
         if (ack !== '0) begin
            e = expQ.pop_front();
            expAck = NREQ'(1) << e.idx;
            total++;
            if (ack !== expAck || rdata !== e.data || err !== '0) begin
               bad++; $display("[TB] FAIL after_reset_grant got ack=%b rdata=%h err=%b required ack=%b rdata=%h err=0000", ack, rdata, err, expAck, e.data);
            end
            req[e.idx] = 1'b0;
            got++;
         end
      end
      total++;
      if (got != 2) begin
         bad++; $display("[TB] FAIL after_reset_count got %0d required 2", got);
         req = '0;
         expQ.delete();
      end
   endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
   task test_timeout;
      int   enCycles;
      int   ackCyc;
      logic [DW-1:0] expData;
      for (int pass = 0; pass < 2; pass++) begin
         memLat = (pass == 0) ? 0 : TOUT;
         memEcho = 1'b0;
         memRdData = 32'h5EED;
         expData = (pass == 0) ? '0 : 32'h5EED;
         @(posedge clk); #1;
         req_we[1] = 1'b0;
         req_addr[1*AW +: AW] = 32'h40;
         req[1] = 1'b1;
         enCycles = 0; ackCyc = -1;
         for (int cyc = 0; cyc < 40 && ackCyc < 0; cyc++) begin
            @(negedge clk);
            if (mem_r_enable === 1'b1) enCycles++;
            if (ack !== '0) begin
               ackCyc = cyc;
               req[1] = 1'b0;
               total++;
               if (ack !== 4'b0010 || rdata !== expData || mem_r_enable !== 1'b0) begin
                  bad++; $display("[TB] FAIL timeout_ack pass %0d got ack=%b rdata=%h r_en=%b required ack=0010 rdata=%h r_en=0", pass, ack, rdata, mem_r_enable, expData);
               end
               total++;
               if (err !== ((pass == 0) ? 4'b0010 : 4'b0000)) begin
                  bad++; $display("[TB] FAIL timeout_err pass %0d got %b required %b", pass, err, (pass == 0) ? 4'b0010 : 4'b0000);
               end
            end
         end
         total++; if (ackCyc != TOUT + 1) begin bad++; $display("[TB] FAIL timeout_latency pass %0d got %0d required %0d", pass, ackCyc, TOUT + 1); end
         total++; if (enCycles != TOUT) begin bad++; $display("[TB] FAIL timeout_enable_cycles pass %0d got %0d required %0d", pass, enCycles, TOUT); end
         if (ackCyc < 0) req[1] = 1'b0;
      end
   endtask
`endif

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_contention();
      test_single_read();
      test_single_write();
      test_stray_done();
      test_reset_mid_busy();
`ifdef MEM_ARBITER_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
